// File: rtl/rgmii_inband_status_decoder.sv
// Recovers RGMII in-band link/speed/duplex from inter-frame-gap receive samples,
// filters them over FILTER_CNT identical samples and forces link down on a sample timeout.
module rgmii_inband_status_decoder #(
    parameter int unsigned FILTER_CNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1250000
) (
    input  logic       rx_mac_aclk,
    input  logic       sys_rst,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic [7:0] gmii_rxd,
    output logic       inband_link_status,
    output logic [1:0] inband_clock_speed,
    output logic       inband_duplex_status,
    output logic       inband_status_valid,
    output logic       inband_status_change
);

    typedef enum logic [1:0] {
        S_INIT,
        S_STABLE,
        S_QUAL
    } state_t;

    localparam logic [3:0]  FILT    = 4'(FILTER_CNT);
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    logic        r_dv;
    logic        r_er;
    logic [7:0]  r_rxd;

    state_t      r_state;
    logic [3:0]  r_cand;
    logic [3:0]  r_count;
    logic [3:0]  r_commit;
    logic        r_valid;
    logic        r_change;
    logic [23:0] r_tcnt;

    logic        w_qual;
    logic        w_valid;
    logic        w_invalid;
    logic [3:0]  w_sample;
    logic        w_match;
    logic [3:0]  w_inc;
    logic        w_toHit;

    state_t      w_stateNext;
    logic [3:0]  w_candNext;
    logic [3:0]  w_countNext;
    logic [3:0]  w_commitNext;
    logic        w_validNext;
    logic        w_changeNext;

    always_ff @(posedge rx_mac_aclk) begin
        r_dv  <= gmii_rx_dv;
        r_er  <= gmii_rx_er;
        r_rxd <= gmii_rxd;
    end

    // Status is packed as {link, speed[1:0], duplex}.
    assign w_qual    = !r_dv && !r_er;
    assign w_valid   = w_qual && (r_rxd[3:0] == r_rxd[7:4]) && (r_rxd[2:1] != 2'b11);
    assign w_invalid = w_qual && !w_valid;
    assign w_sample  = {r_rxd[0], r_rxd[2:1], r_rxd[3]};
    assign w_match   = (r_count != 4'd0) && (w_sample == r_cand);
    assign w_inc     = r_count + 4'd1;
    assign w_toHit   = TO_EN && !w_valid && (r_tcnt == TO_LAST);

    always_comb begin
        w_stateNext  = r_state;
        w_candNext   = r_cand;
        w_countNext  = r_count;
        w_commitNext = r_commit;
        w_validNext  = r_valid;
        w_changeNext = 1'b0;

        if (w_valid) begin
            if (r_state != S_INIT && w_sample == r_commit) begin
                w_countNext = 4'd0;
                w_stateNext = S_STABLE;
            end else begin
                if (r_state != S_STABLE && w_match) begin
                    w_countNext = w_inc;
                end else begin
                    w_candNext  = w_sample;
                    w_countNext = 4'd1;
                end
                // A commit only ever happens with a value differing from the committed one,
                // except the first one out of S_INIT, which must pulse regardless.
                if (w_countNext == FILT) begin
                    w_commitNext = w_sample;
                    w_changeNext = 1'b1;
                    w_validNext  = 1'b1;
                    w_countNext  = 4'd0;
                    w_stateNext  = S_STABLE;
                end else if (r_state != S_INIT) begin
                    w_stateNext = S_QUAL;
                end
            end
        end else if (w_toHit) begin
            w_commitNext[3] = 1'b0;
            w_changeNext    = r_commit[3];
            w_validNext     = 1'b1;
            w_countNext     = 4'd0;
            w_stateNext     = S_STABLE;
        end else if (w_invalid) begin
            w_countNext = 4'd0;
        end
    end

    always_ff @(posedge rx_mac_aclk) begin
        if (sys_rst) begin
            r_state  <= S_INIT;
            r_cand   <= 4'd0;
            r_count  <= 4'd0;
            r_commit <= 4'd0;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cand   <= w_candNext;
            r_count  <= w_countNext;
            r_commit <= w_commitNext;
            r_valid  <= w_validNext;
            r_change <= w_changeNext;
        end
    end

    // Saturating counter: once past the threshold it can never match again until a valid sample.
    always_ff @(posedge rx_mac_aclk) begin
        if (sys_rst || w_valid) begin
            r_tcnt <= 24'd0;
        end else if (r_tcnt != 24'hFF_FFFF) begin
            r_tcnt <= r_tcnt + 24'd1;
        end
    end

    assign inband_link_status   = r_commit[3];
    assign inband_clock_speed   = r_commit[2:1];
    assign inband_duplex_status = r_commit[0];
    assign inband_status_valid  = r_valid;
    assign inband_status_change = r_change;

endmodule

// File: tb/tb_rgmii_inband_status_decoder.sv
// Directed plus randomized bench for rgmii_inband_status_decoder; expectations come from a
// sample-history model (run length of identical valid samples, cycles since the last valid sample).
module tb_rgmii_inband_status_decoder;

    localparam int FC = 4;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       dv = 1'b1;
    logic       er = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       link;
    logic [1:0] speed;
    logic       duplex;
    logic       stValid;
    logic       stChange;

    rgmii_inband_status_decoder #(
        .FILTER_CNT    (FC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .rx_mac_aclk         (clk),
        .sys_rst             (sys_rst),
        .gmii_rx_dv          (dv),
        .gmii_rx_er          (er),
        .gmii_rxd            (rxd),
        .inband_link_status  (link),
        .inband_clock_speed  (speed),
        .inband_duplex_status(duplex),
        .inband_status_valid (stValid),
        .inband_status_change(stChange)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int tickNo     = 0;
    int changeSeen = 0;

    bit       mValid, mLink, mDuplex, mChange;
    bit [1:0] mSpeed;
    bit [3:0] runNib;
    int       runLen, sinceValid;

    bit         pHave = 1'b0;
    bit         pDv, pEr;
    logic [7:0] pRxd;

    function automatic void modelReset();
        mValid = 0; mLink = 0; mSpeed = 2'b00; mDuplex = 0; mChange = 0;
        runLen = 0; sinceValid = 0;
    endfunction

    // One received cycle: a value is committed once it has been seen FC times in a row
    // (ignoring non-qualifying cycles) and differs from what is already committed.
    function automatic void modelStep(bit d, bit e, logic [7:0] x);
        bit [3:0] n;
        n = x[3:0];
        mChange = 0;
        if (!d && !e && x[3:0] == x[7:4] && x[2:1] != 2'b11) begin
            sinceValid = 0;
            if (mValid && n[0] == mLink && n[2:1] == mSpeed && n[3] == mDuplex) begin
                runLen = 0;
            end else begin
                if (runLen > 0 && n == runNib) runLen++;
                else begin
                    runNib = n;
                    runLen = 1;
                end
                if (runLen == FC) begin
                    mLink = n[0]; mSpeed = n[2:1]; mDuplex = n[3];
                    mValid = 1; mChange = 1; runLen = 0;
                end
            end
        end else begin
            if (!d && !e) runLen = 0;
            sinceValid++;
            if (sinceValid == TO) begin
                mChange = mLink;
                mLink = 0; mValid = 1; runLen = 0;
            end
        end
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, tickNo);
        end
    endtask

    task automatic checkOutput();
        checkVal("link",   32'(link),     32'(mLink));
        checkVal("speed",  32'(speed),    32'(mSpeed));
        checkVal("duplex", 32'(duplex),   32'(mDuplex));
        checkVal("valid",  32'(stValid),  32'(mValid));
        checkVal("change", 32'(stChange), 32'(mChange));
    endtask

    task automatic applyStimulus(input bit r, input bit d, input bit e, input logic [7:0] x);
        @(negedge clk);
        sys_rst = r; dv = d; er = e; rxd = x;
        @(posedge clk);
        #1;
        tickNo++;
        if (r) modelReset();
        else if (pHave) modelStep(pDv, pEr, pRxd);
        pHave = 1; pDv = d; pEr = e; pRxd = x;
        checkOutput();
        if (stChange === 1'b1) changeSeen++;
    endtask

    task automatic sample(input logic [7:0] x);
        applyStimulus(0, 0, 0, x);
    endtask

    task automatic idleTick();
        applyStimulus(0, 1, 0, 8'h00);
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 8'($urandom));
    endtask

    initial begin
        int         lastValid;
        int         fallTick;
        int         p;
        logic [7:0] x;
        bit [3:0]   lastNib;
        bit [3:0]   nibs [7];
        nibs = '{4'h5, 4'hD, 4'h4, 4'hC, 4'h1, 4'h0, 4'h8};
        lastNib = 4'h5;

        applyStimulus(1, 1, 0, 8'h00);
        applyStimulus(1, 1, 0, 8'h00);
        checkVal("rst_link",  32'(link),    32'd0);
        checkVal("rst_valid", 32'(stValid), 32'd0);

        // 0x55: link up, 1G, half duplex
        repeat (4) sample(8'h55);
        checkVal("pre_commit_link", 32'(link), 32'd0);
        idleTick();
        checkVal("c55_link",   32'(link),     32'd1);
        checkVal("c55_speed",  32'(speed),    32'd2);
        checkVal("c55_duplex", 32'(duplex),   32'd0);
        checkVal("c55_change", 32'(stChange), 32'd1);
        checkVal("c55_valid",  32'(stValid),  32'd1);
        idleTick();
        checkVal("c55_change_off", 32'(stChange), 32'd0);

        // A frame between samples must not reset the filter count
        repeat (3) sample(8'hDD);
        frame(100);
        sample(8'hDD);
        checkVal("pre_dd_duplex", 32'(duplex), 32'd0);
        idleTick();
        checkVal("cdd_duplex", 32'(duplex),   32'd1);
        checkVal("cdd_speed",  32'(speed),    32'd2);
        checkVal("cdd_change", 32'(stChange), 32'd1);

        repeat (4) sample(8'h55);
        idleTick();
        checkVal("back55_duplex", 32'(duplex), 32'd0);

        // 0x44 is the equal-nibble link-down code; returning to 0x55 abandons it
        changeSeen = 0;
        repeat (3) sample(8'h44);
        sample(8'h55);
        idleTick();
        checkVal("abandon_changes", 32'(changeSeen), 32'd0);
        checkVal("abandon_link",    32'(link),       32'd1);

        changeSeen = 0;
        repeat (2) sample(8'h44);
        sample(8'h5D);
        repeat (3) sample(8'h44);
        idleTick();
        checkVal("restart_link_held", 32'(link),       32'd1);
        checkVal("restart_no_change", 32'(changeSeen), 32'd0);
        sample(8'h44);
        idleTick();
        checkVal("restart_link_down", 32'(link),       32'd0);
        checkVal("restart_one_chg",   32'(changeSeen), 32'd1);

        // Timeout: counted from the capture of the last valid sample, same latency as a commit
        repeat (5) sample(8'h55);
        lastValid = tickNo;
        checkVal("to_link_up", 32'(link), 32'd1);
        changeSeen = 0;
        fallTick = -1;
        for (int i = 0; i < 1200; i++) begin
            applyStimulus(0, 1, 0, 8'($urandom));
            if (fallTick < 0 && link === 1'b0) fallTick = tickNo;
        end
        checkVal("to_delay",   32'(fallTick - lastValid), 32'(TO + 1));
        checkVal("to_changes", 32'(changeSeen),           32'd1);
        checkVal("to_speed",   32'(speed),                32'd2);
        checkVal("to_valid",   32'(stValid),              32'd1);

        // Reset in the middle of qualification discards the partial count
        repeat (4) sample(8'h55);
        repeat (2) sample(8'hDD);
        applyStimulus(1, 1, 0, 8'h00);
        checkVal("midrst_link",  32'(link),    32'd0);
        checkVal("midrst_valid", 32'(stValid), 32'd0);
        repeat (3) sample(8'hDD);
        idleTick();
        checkVal("midrst_3_valid", 32'(stValid), 32'd0);
        sample(8'hDD);
        idleTick();
        checkVal("midrst_4_valid",  32'(stValid), 32'd1);
        checkVal("midrst_4_duplex", 32'(duplex),  32'd1);

        for (int i = 0; i < 4000; i++) begin
            p = $urandom_range(0, 999);
            if (p < 3) applyStimulus(1, 1, 0, 8'($urandom));
            else if (p < 5) frame(TO + $urandom_range(0, 60));
            else if (p < 100) applyStimulus(0, 1, 1'($urandom_range(0, 1)), 8'($urandom));
            else if (p < 150) applyStimulus(0, 0, 1, 8'($urandom));
            else if (p < 230) begin
                x = 8'($urandom);
                if (x[3:0] == x[7:4] && x[2:1] != 2'b11) x[7:4] = ~x[3:0];
                sample(x);
            end else begin
                if ($urandom_range(0, 99) < 25) lastNib = nibs[$urandom_range(0, 6)];
                sample({lastNib, lastNib});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
